pwm_capture_counter: RTL and testbench
======================================

PWM_CAPTURE_COUNTER -- requirements
Module: pwm_capture_counter

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the internal counter and of both result outputs.
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flop stages synchronising pwm_in (minimum 2).
REQ-003 Parameter SATURATE, default 1: 1 = counter saturates at all-ones; 0 = counter wraps to 0.
REQ-004 Port clock, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: active-high measurement enable.
REQ-007 Port pwm_in, input, 1 bit: asynchronous PWM input.
REQ-008 Port high_count, output, WIDTH bits: number of clock cycles the last complete pulse was high.
REQ-009 Port period_count, output, WIDTH bits: number of clock cycles from rising edge to rising edge of the last complete pulse.
REQ-010 Port overflow, output, 1 bit: the counter saturated or wrapped during the reported period.
REQ-011 Port valid, output, 1 bit: the result outputs hold an unconsumed measurement.
REQ-012 Port ready, input, 1 bit: the consumer accepts the result when valid and ready are both high.
REQ-013 Port overrun, output, 1 bit: sticky flag; a completed measurement was dropped.

Function
REQ-014 pwm_in SHALL pass through SYNC_STAGES flops to give pwm_s; a further flop gives pwm_d; rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
REQ-015 FSM states SHALL be IDLE, HIGH and LOW; the reset state is IDLE.
REQ-016 IDLE -> HIGH on rise while enable=1; the counter SHALL load 1; no result is emitted.
REQ-017 In HIGH, every cycle SHALL increment the counter; on fall, the FSM SHALL capture the counter into high_reg and go to LOW, and the counter still increments in that cycle.
REQ-018 In LOW, every cycle SHALL increment the counter; on rise, the FSM SHALL publish results, load the counter with 1 and go to HIGH.
REQ-019 Publishing SHALL set high_count <= high_reg, period_count <= counter, overflow <= ovf_flag and valid <= 1; the outputs are visible in the cycle after the rise detection.
REQ-020 For a steady input of H cycles high and L cycles low, the block SHALL report high_count = H and period_count = H+L.
REQ-021 When SATURATE=1, a counter at all-ones SHALL hold and set ovf_flag; when SATURATE=0, it SHALL wrap to 0 and set ovf_flag; ovf_flag is cleared whenever the counter loads 1.
REQ-022 If high_reg is captured while ovf_flag=1, high_count SHALL report the saturated or wrapped value, and overflow=1 for that result.
REQ-023 Handshake: valid SHALL stay high with stable outputs until the cycle in which ready=1; valid falls in the following cycle unless a new publish occurs in the same cycle.
REQ-024 A publish in the same cycle as acceptance SHALL load the new result and keep valid=1.
REQ-025 A publish while valid=1 and ready=0 SHALL drop the new result, keep the old outputs and set overrun=1; overrun clears only on reset.
REQ-026 enable=0 SHALL force the FSM to IDLE and hold the counter at the next clock; valid and pending results are unaffected.
REQ-027 A rise and a fall cannot occur in the same cycle; the FSM SHALL ignore a fall in LOW and a rise in HIGH.

Reset
REQ-028 Reset SHALL clear the synchroniser flops, pwm_d, the counter, high_reg, ovf_flag, high_count, period_count, overflow, valid and overrun to 0, and set the FSM to IDLE.
REQ-029 Reset mid-measurement SHALL discard the partial measurement; the first result after reset requires one full rise-to-rise interval following the first rise.

Structure
REQ-030 The state encoding and the default WIDTH/SYNC_STAGES constants SHALL live in the shared package pwm_pkg.
REQ-031 The synchroniser and edge detector SHALL be the sub-module pwm_edge_sync, with outputs pwm_s, rise and fall.

Verification
REQ-032 WIDTH=16, ready=1, pwm of 30 cycles high and 70 cycles low repeated -> every result reads high_count=30, period_count=100, overflow=0.
REQ-033 WIDTH=8, SATURATE=1, 300 cycles high and 100 cycles low -> high_count=255, period_count=255, overflow=1.
REQ-034 WIDTH=8, SATURATE=0, 200 cycles high and 100 cycles low -> high_count=200, period_count=44, overflow=1.
REQ-035 ready=0 across two publishes -> first result held, valid=1, overrun=1; ready then pulsed for 1 cycle -> valid=0 on the next cycle.
REQ-036 Reset asserted in LOW after 10 cycles, then a 5-high/5-low input -> no result before the second rise; first result high_count=5, period_count=10.
REQ-037 enable dropped for 20 cycles mid-pulse -> no result emitted; after enable returns, the first result appears on the second rise.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM capture counter.
package pwm_pkg;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;
endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises the asynchronous PWM input and derives single-cycle edge strobes.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pwm_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync  <= '0;
      r_pwm_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_pwm_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign pwm_s = r_sync[SYNC_STAGES-1];
  assign rise  = pwm_s & ~r_pwm_d;
  assign fall  = ~pwm_s & r_pwm_d;
endmodule

// File: rtl/pwm_capture_counter.sv
// Measures high time and period of a PWM input; results are offered on a valid/ready pair.
module pwm_capture_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SATURATE    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period_count,
  output logic             overflow,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_pwm_s, w_rise, w_fall;
  logic             w_all_ones;
  logic [WIDTH-1:0] w_cnt_next;

  state_t           r_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_high_reg;
  logic             r_ovf_flag;

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .pwm_s  (w_pwm_s),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  assign w_all_ones = &r_counter;
  assign w_cnt_next = (w_all_ones && (SATURATE != 0)) ? r_counter : r_counter + ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_counter    <= '0;
      r_high_reg   <= '0;
      r_ovf_flag   <= 1'b0;
      high_count   <= '0;
      period_count <= '0;
      overflow     <= 1'b0;
      valid        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_counter  <= ONE;
              r_ovf_flag <= 1'b0;
              r_state    <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            r_counter <= w_cnt_next;
            if (w_all_ones) r_ovf_flag <= 1'b1;
            if (w_fall) begin
              r_high_reg <= r_counter;
              r_state    <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_counter  <= ONE;
              r_ovf_flag <= 1'b0;
              r_state    <= ST_HIGH;
              // A held, unaccepted result wins; the new one is dropped and flagged.
              if (!valid || ready) begin
                high_count   <= r_high_reg;
                period_count <= r_counter;
                overflow     <= r_ovf_flag;
                valid        <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              r_counter <= w_cnt_next;
              if (w_all_ones) r_ovf_flag <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // A rise strobe always coincides with a high synchronised level.
  a_rise_level: assert property (@(posedge clock) disable iff (reset) !(w_rise && !w_pwm_s));
endmodule

// File: tb/tb_pwm_capture_counter.sv
// Directed bench: one 16-bit DUT plus two 8-bit DUTs for saturate and wrap behaviour.
module tb_pwm_capture_counter;
  logic        clock = 1'b0;
  logic        reset, enable, ready;
  logic [2:0]  pwm;
  logic [15:0] hc0, pc0;
  logic [7:0]  hc1, pc1, hc2, pc2;
  logic        ov0, ov1, ov2, v0, v1, v2, orun0, orun1, orun2;

  int ncomp = 0, nfail = 0;
  int res_cnt[3], res_bad[3], last_h[3], last_p[3], last_o[3];
  int exp_h[3], exp_p[3], exp_o[3];

  always #5 clock = ~clock;

  pwm_capture_counter #(.WIDTH(16), .SYNC_STAGES(2), .SATURATE(1)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .pwm_in(pwm[0]),
    .high_count(hc0), .period_count(pc0), .overflow(ov0), .valid(v0),
    .ready(ready), .overrun(orun0));
  pwm_capture_counter #(.WIDTH(8), .SYNC_STAGES(2), .SATURATE(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .pwm_in(pwm[1]),
    .high_count(hc1), .period_count(pc1), .overflow(ov1), .valid(v1),
    .ready(ready), .overrun(orun1));
  pwm_capture_counter #(.WIDTH(8), .SYNC_STAGES(2), .SATURATE(0)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .pwm_in(pwm[2]),
    .high_count(hc2), .period_count(pc2), .overflow(ov2), .valid(v2),
    .ready(ready), .overrun(orun2));

  task automatic check(input string tag, input int got, input int expv);
    ncomp++;
    assert (got === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  // Log every result the consumer actually takes.
  task automatic rec(input int s, input logic v, input int h, input int p, input logic o);
    if (v && ready) begin
      res_cnt[s]++;
      last_h[s] = h;
      last_p[s] = p;
      last_o[s] = int'(o);
      if (h != exp_h[s] || p != exp_p[s] || int'(o) != exp_o[s]) res_bad[s]++;
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
    rec(0, v0, int'(hc0), int'(pc0), ov0);
    rec(1, v1, int'(hc1), int'(pc1), ov1);
    rec(2, v2, int'(hc2), int'(pc2), ov2);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      res_cnt[i] = 0; res_bad[i] = 0; last_h[i] = -1; last_p[i] = -1; last_o[i] = -1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    clr();
  endtask

  task automatic set_exp(input int s, input int h, input int p, input int o);
    exp_h[s] = h; exp_p[s] = p; exp_o[s] = o;
  endtask

  // n full periods followed by the rise that completes the last one.
  task automatic pattern(input int s, input int h, input int l, input int n);
    repeat (n) begin
      pwm[s] = 1'b1; steps(h);
      pwm[s] = 1'b0; steps(l);
    end
    pwm[s] = 1'b1; steps(h);
    pwm[s] = 1'b0; steps(4);
  endtask

  task automatic check_result(input string tag, input int s, input int n,
                              input int h, input int p, input int o);
    check({tag, "_count"}, res_cnt[s], n);
    check({tag, "_bad"},   res_bad[s], 0);
    check({tag, "_high"},  last_h[s],  h);
    check({tag, "_period"}, last_p[s], p);
    check({tag, "_ovf"},   last_o[s],  o);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ready = 1'b1; pwm = '0;
    for (int i = 0; i < 3; i++) set_exp(i, 0, 0, 0);
    do_reset();

    check("rst_valid",   int'(v0),    0);
    check("rst_high",    int'(hc0),   0);
    check("rst_period",  int'(pc0),   0);
    check("rst_ovf",     int'(ov0),   0);
    check("rst_overrun", int'(orun0), 0);

    // Steady 30/70 input.
    set_exp(0, 30, 100, 0);
    pattern(0, 30, 70, 4);
    check_result("steady", 0, 4, 30, 100, 0);

    // 8-bit saturating counter, high time longer than full scale.
    set_exp(1, 255, 255, 1);
    pattern(1, 300, 100, 1);
    check_result("sat", 1, 1, 255, 255, 1);

    // 8-bit wrapping counter: 300 mod 256 = 44.
    set_exp(2, 200, 44, 1);
    pattern(2, 200, 100, 1);
    check_result("wrap", 2, 1, 200, 44, 1);

    // Consumer stalls across two publishes; second (5/30) must be dropped.
    do_reset();
    ready = 1'b0;
    pwm[0] = 1'b1; steps(10);
    pwm[0] = 1'b0; steps(10);
    pwm[0] = 1'b1; steps(5);
    pwm[0] = 1'b0; steps(25);
    pwm[0] = 1'b1; steps(10);
    check("stall_valid",   int'(v0),    1);
    check("stall_high",    int'(hc0),   10);
    check("stall_period",  int'(pc0),   20);
    check("stall_overrun", int'(orun0), 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("accept_valid",   int'(v0),    0);
    check("sticky_overrun", int'(orun0), 1);
    steps(3);
    check("sticky_overrun2", int'(orun0), 1);
    ready = 1'b1;
    pwm[0] = 1'b0; steps(5);

    // Reset while in LOW discards the partial measurement.
    do_reset();
    pwm[0] = 1'b1; steps(5);
    pwm[0] = 1'b0; steps(10);
    check("pre_reset_none", res_cnt[0], 0);
    reset = 1'b1; step(); reset = 1'b0;
    clr();
    check("post_reset_overrun", int'(orun0), 0);
    set_exp(0, 5, 10, 0);
    pwm[0] = 1'b1; steps(5);
    pwm[0] = 1'b0; steps(5);
    check("first_rise_none", res_cnt[0], 0);
    pwm[0] = 1'b1; steps(5);
    pwm[0] = 1'b0; steps(2);
    check_result("after_reset", 0, 1, 5, 10, 0);

    // Enable dropped mid-pulse: nothing is reported until two fresh rises.
    do_reset();
    set_exp(0, 10, 20, 0);
    pwm[0] = 1'b1; steps(4);
    enable = 1'b0;
    steps(6);
    pwm[0] = 1'b0; steps(14);
    enable = 1'b1;
    check("disabled_none", res_cnt[0], 0);
    pwm[0] = 1'b1; steps(10);
    pwm[0] = 1'b0; steps(10);
    check("reenable_first_rise_none", res_cnt[0], 0);
    pwm[0] = 1'b1; steps(10);
    pwm[0] = 1'b0; steps(2);
    check_result("reenable", 0, 1, 10, 20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
